// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared types for the MIPS load/store unit
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        READ2,
        WRITE2,
        RESP
    } lsu_state_e;

    typedef logic [7:0] lane_t;

endpackage

// File: rtl/mips_lsu_if.sv
// rtl/mips_lsu_if.sv - request/response and byte-lane memory bus of the load/store unit
interface mips_lsu_if #(
    parameter int ADDR_W    = 32,
    parameter int NUM_LANES = 4
);
    import mips_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_size;
    logic                      req_signed;
    logic [ADDR_W-1:0]         req_addr;
    logic [8*NUM_LANES-1:0]    req_wdata;
    logic                      resp_valid;
    logic [8*NUM_LANES-1:0]    resp_rdata;
    logic                      resp_err;
    logic [ADDR_W-1:0]         mem_addr;
    lane_t [NUM_LANES-1:0]     mem_data_out;
    lane_t [NUM_LANES-1:0]     mem_data_in;
    logic                      mem_write_en;
    logic [NUM_LANES-1:0]      mem_byte_en;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_data_in, mem_write_en, mem_byte_en
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_data_in, mem_write_en, mem_byte_en
    );

endinterface

// File: rtl/mips_lsu_lane_align.sv
// rtl/mips_lsu_lane_align.sv - store lane placement/byte enables and load extraction/extension
module mips_lsu_lane_align
    import mips_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int OFF_W     = $clog2(NUM_LANES)
) (
    input  logic [OFF_W-1:0]     off,
    input  logic [1:0]           size,
    input  logic                 is_signed,
    input  lane_t [NUM_LANES-1:0] wdata,
    input  lane_t [NUM_LANES-1:0] rd_lo,
    input  lane_t [NUM_LANES-1:0] rd_hi,
    output lane_t [NUM_LANES-1:0] st_lo,
    output lane_t [NUM_LANES-1:0] st_hi,
    output logic [NUM_LANES-1:0]  be_lo,
    output logic [NUM_LANES-1:0]  be_hi,
    output lane_t [NUM_LANES-1:0] ld_data
);

    lane_t [2*NUM_LANES-1:0] st_w;
    lane_t [2*NUM_LANES-1:0] rd_w;
    logic  [2*NUM_LANES-1:0] be_w;
    logic                    sign;
    int                      o;
    int                      n;

    // The access is viewed over a two-word window so a boundary-crossing
    // access simply spills into the upper word.
    always_comb begin
        o       = int'(off);
        n       = 32'(1) << size;
        rd_w    = {rd_hi, rd_lo};
        st_w    = '0;
        be_w    = '0;
        ld_data = '0;
        sign    = 1'b0;
        for (int i = 0; i < 2*NUM_LANES; i++) begin
            if (i >= o && i < o + n) begin
                be_w[i] = 1'b1;
                st_w[i] = wdata[OFF_W'(i - o)];
            end
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            if (j < n) ld_data[j] = rd_w[(OFF_W+1)'(o + j)];
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            if (j == n - 1) sign = is_signed & ld_data[j][7];
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            if (j >= n) ld_data[j] = {8{sign}};
        end
    end

    assign st_lo = st_w[NUM_LANES-1:0];
    assign st_hi = st_w[2*NUM_LANES-1:NUM_LANES];
    assign be_lo = be_w[NUM_LANES-1:0];
    assign be_hi = be_w[2*NUM_LANES-1:NUM_LANES];

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - MIPS load/store unit FSM; MIPS_LSU_MISALIGN_SPLIT_EN splits misaligned accesses
module mips_lsu
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int NUM_LANES   = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_b,
    mips_lsu_if.slave  bus,
    output logic       busy
);

    localparam int OFF_W = $clog2(NUM_LANES);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    lsu_state_e            state, state_nx;
    logic [ADDR_W-1:0]     word_addr;
    logic [OFF_W-1:0]      off_q;
    logic [1:0]            size_q;
    logic                  signed_q, write_q, err_q, cross_q;
    lane_t [NUM_LANES-1:0] wdata_q, rd_lo_q, rd_hi_q;
    logic [CNT_W-1:0]      cnt;

    logic                  accept, acc_illegal, acc_err, acc_cross;
    logic [OFF_W-1:0]      acc_off;
    lane_t [NUM_LANES-1:0] st_lo, st_hi, ld_data;
    logic [NUM_LANES-1:0]  be_lo, be_hi;

    assign accept      = bus.req_valid && (state == IDLE);
    assign acc_off     = bus.req_addr[OFF_W-1:0];
    assign acc_illegal = 32'(bus.req_size) > 32'(OFF_W);

`ifdef MIPS_LSU_MISALIGN_SPLIT_EN
    assign acc_err   = acc_illegal;
    assign acc_cross = ({1'b0, acc_off} + (OFF_W+1)'(32'd1 << bus.req_size))
                       > (OFF_W+1)'(NUM_LANES);
`else
    logic acc_misal;
    assign acc_misal = |(acc_off & OFF_W'((32'd1 << bus.req_size) - 32'd1));
    assign acc_err   = acc_illegal || acc_misal;
    assign acc_cross = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (accept) state_nx = acc_err ? RESP : (bus.req_write ? WRITE : READ);
            WRITE:  state_nx = cross_q ? WRITE2 : RESP;
            WRITE2: state_nx = RESP;
            READ:   if (cnt == CNT_LAST) state_nx = cross_q ? READ2 : RESP;
            READ2:  if (cnt == CNT_LAST) state_nx = RESP;
            RESP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            word_addr <= '0;
            off_q     <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            cross_q   <= 1'b0;
            wdata_q   <= '0;
            rd_lo_q   <= '0;
            rd_hi_q   <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                word_addr <= bus.req_addr & ~ADDR_W'(NUM_LANES - 1);
                off_q     <= acc_off;
                size_q    <= bus.req_size;
                signed_q  <= bus.req_signed;
                write_q   <= bus.req_write;
                err_q     <= acc_err;
                cross_q   <= acc_cross;
                wdata_q   <= bus.req_wdata;
                rd_lo_q   <= '0;
                rd_hi_q   <= '0;
            end
            if (state_nx != state)
                cnt <= '0;
            else if (state == READ || state == READ2)
                cnt <= cnt + 1'b1;
            // Memory data is only guaranteed on the last cycle of the hold window.
            if (state == READ && cnt == CNT_LAST)  rd_lo_q <= bus.mem_data_out;
            if (state == READ2 && cnt == CNT_LAST) rd_hi_q <= bus.mem_data_out;
        end
    end

    mips_lsu_lane_align #(.NUM_LANES(NUM_LANES)) u_align (
        .off       (off_q),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .rd_lo     (rd_lo_q),
        .rd_hi     (rd_hi_q),
        .st_lo     (st_lo),
        .st_hi     (st_hi),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .ld_data   (ld_data)
    );

    always_comb begin
        bus.req_ready    = (state == IDLE);
        busy             = (state != IDLE);
        bus.resp_valid   = 1'b0;
        bus.resp_err     = 1'b0;
        bus.resp_rdata   = '0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;
        bus.mem_byte_en  = '0;
        case (state)
            WRITE: begin
                bus.mem_addr     = word_addr;
                bus.mem_data_in  = st_lo;
                bus.mem_byte_en  = be_lo;
                bus.mem_write_en = 1'b1;
            end
            WRITE2: begin
                bus.mem_addr     = word_addr + ADDR_W'(NUM_LANES);
                bus.mem_data_in  = st_hi;
                bus.mem_byte_en  = be_hi;
                bus.mem_write_en = 1'b1;
            end
            READ: begin
                bus.mem_addr    = word_addr;
                bus.mem_byte_en = be_lo;
            end
            READ2: begin
                bus.mem_addr    = word_addr + ADDR_W'(NUM_LANES);
                bus.mem_byte_en = be_hi;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                if (!err_q && !write_q) bus.resp_rdata = ld_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_lsu.sv
// tb/tb_mips_lsu.sv - directed self-checking bench for mips_lsu (4 lanes, read latency 2)
module tb_mips_lsu;
    import mips_pkg::*;

    localparam int MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mips_lsu_if #(.ADDR_W(32), .NUM_LANES(4)) bus ();

    mips_lsu #(.ADDR_W(32), .NUM_LANES(4), .MEM_LATENCY(MEM_LAT)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave),
        .busy  (busy)
    );

    logic [31:0] mem [256];
    logic [31:0] hold_addr;
    int          hold;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] last_waddr, last_wdata;
    logic [3:0]  last_wbe, last_rbe;
    logic [31:0] rd_word;

    // Read data only becomes valid once an address has been held MEM_LAT cycles.
    always_comb begin
        if (hold_addr == bus.mem_addr && hold >= MEM_LAT - 1)
            rd_word = mem[bus.mem_addr[9:2]];
        else
            rd_word = 32'h5A5A_5A5A;
    end
    assign bus.mem_data_out = rd_word;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hold      <= 0;
            hold_addr <= '1;
        end else if (bus.mem_byte_en != 4'b0 && !bus.mem_write_en) begin
            hold      <= (hold > 0 && hold_addr == bus.mem_addr) ? hold + 1 : 1;
            hold_addr <= bus.mem_addr;
        end else begin
            hold <= 0;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_byte_en[i]) mem[bus.mem_addr[9:2]][8*i +: 8] = bus.mem_data_in[i];
            wr_cnt++;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_data_in;
            last_wbe   = bus.mem_byte_en;
        end else if (bus.mem_byte_en != 4'b0) begin
            rd_cnt++;
            last_rbe = bus.mem_byte_en;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_write  = ~wr;
        bus.req_size   = 2'd0;
        bus.req_signed = ~sg;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'hFFFF_FFFF;
        lat = 0;
        rd  = 32'hDEAD_0000;
        er  = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, w0, r0, nres, idx;
    logic [31:0] got [3];
    logic        acc;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h80] = 32'h8011_2233;
        mem[8'h84] = 32'h8001_1234;
        mem[8'h41] = 32'h4433_2211;
        mem[8'hC0] = 32'h0BAD_0001;
        mem[8'hC1] = 32'h0BAD_0002;
        mem[8'hC2] = 32'h0BAD_0003;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", bus.req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_write_en", bus.mem_write_en, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        rst_b = 1'b1;

        w0 = wr_cnt;
        access(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, rd, er, lat);
        check("sw_lat", lat, 2);
        check("sw_err", er, 0);
        check("sw_rdata", rd, 0);
        check("sw_writes", wr_cnt - w0, 1);
        check("sw_addr", last_waddr, 32'h100);
        check("sw_be", last_wbe, 4'b1111);
        check("sw_lanes", last_wdata, 32'hDEAD_BEEF);

        access(1'b0, SZ_BYTE, 1'b1, 32'h203, 32'h0, rd, er, lat);
        check("lb_lat", lat, 3);
        check("lb_rdata", rd, 32'hFFFF_FF80);
        check("lb_be", last_rbe, 4'b1000);
        access(1'b0, SZ_BYTE, 1'b0, 32'h203, 32'h0, rd, er, lat);
        check("lbu_rdata", rd, 32'h0000_0080);
        access(1'b0, SZ_BYTE, 1'b1, 32'h201, 32'h0, rd, er, lat);
        check("lb_pos_rdata", rd, 32'h0000_0022);

        access(1'b1, SZ_HALF, 1'b0, 32'h102, 32'hFFFF_A5A5, rd, er, lat);
        check("sh_lat", lat, 2);
        check("sh_be", last_wbe, 4'b1100);
        check("sh_lanes", last_wdata, 32'hA5A5_0000);
        access(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, rd, er, lat);
        check("lw_after_sh", rd, 32'hA5A5_BEEF);

        access(1'b0, SZ_HALF, 1'b1, 32'h212, 32'h0, rd, er, lat);
        check("lh_rdata", rd, 32'hFFFF_8001);
        access(1'b0, SZ_HALF, 1'b0, 32'h212, 32'h0, rd, er, lat);
        check("lhu_rdata", rd, 32'h0000_8001);
        access(1'b0, SZ_HALF, 1'b1, 32'h210, 32'h0, rd, er, lat);
        check("lh_low_rdata", rd, 32'h0000_1234);

        w0 = wr_cnt; r0 = rd_cnt;
        access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, rd, er, lat);
        check("illegal_err", er, 1);
        check("illegal_lat", lat, 1);
        check("illegal_nomem", (wr_cnt - w0) + (rd_cnt - r0), 0);

        w0 = wr_cnt; r0 = rd_cnt;
        access(1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, rd, er, lat);
`ifdef MIPS_LSU_MISALIGN_SPLIT_EN
        check("lw_split_err", er, 0);
        check("lw_split_lat", lat, 5);
        check("lw_split_rdata", rd, 32'h11A5_A5BE);
        check("lw_split_reads", rd_cnt - r0, 4);
`else
        check("lw_mis_err", er, 1);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_rdata", rd, 0);
        check("lw_mis_nomem", (wr_cnt - w0) + (rd_cnt - r0), 0);
        w0 = wr_cnt;
        access(1'b1, SZ_HALF, 1'b0, 32'h101, 32'h1234, rd, er, lat);
        check("sh_mis_err", er, 1);
        check("sh_mis_nowrite", wr_cnt - w0, 0);
`endif

        // Reset while a load is holding the memory address.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = SZ_WORD;
        bus.req_addr = 32'h300;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_read_busy", busy, 1);
        check("mid_read_addr", bus.mem_addr, 32'h300);
        #2 rst_b = 1'b0;
        #1;
        check("async_rst_addr", bus.mem_addr, 0);
        check("async_rst_be", bus.mem_byte_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", bus.req_ready, 1);
        @(negedge clk);
        rst_b = 1'b1;
        nres = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) nres++;
        end
        check("post_rst_no_resp", nres, 0);
        check("post_rst_ready", bus.req_ready, 1);

        // Three loads with req_valid held high throughout.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = SZ_WORD;
        bus.req_signed = 1'b0; bus.req_addr = 32'h300;
        idx = 0; nres = 0;
        for (int c = 0; c < 60 && nres < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.resp_valid) begin
                if (nres < 3) got[nres] = bus.resp_rdata;
                nres++;
            end
            acc = bus.req_valid && bus.req_ready;
            if (acc) check("b2b_accept_after_resp", nres, idx);
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) bus.req_addr = 32'h300 + 32'(4 * idx);
                else bus.req_valid = 1'b0;
            end
        end
        check("b2b_resp_count", nres, 3);
        check("b2b_data0", got[0], 32'h0BAD_0001);
        check("b2b_data1", got[1], 32'h0BAD_0002);
        check("b2b_data2", got[2], 32'h0BAD_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
